// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-SRAM Wishbone port.
package imem_pkg;

  localparam int          IMEM_ADDR_W = 9;
  localparam int          IMEM_DATA_W = 32;
  localparam logic [31:0] IMEM_BASE   = 32'h3000_0000;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RWAIT,
    ACK
  } imemState_t;

endpackage

// File: rtl/imem_wb_port.sv
// Wishbone classic responder that gives the host read/write access to imem port 0.
// Handshake: a request is cyc&stb sampled in IDLE; wbs_ack_o pulses for one cycle, and dropping cyc aborts.
import imem_pkg::*;

module imem_wb_port #(
  parameter int          ADDR_W    = IMEM_ADDR_W,
  parameter int          DATA_W    = IMEM_DATA_W,
  parameter logic [31:0] BASE_ADDR = IMEM_BASE
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  input  logic              hold_i,
  output logic              csb0,
  output logic              web0,
  output logic [3:0]        wmask0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] dout0,
  output logic              busy_o
);

  imemState_t state;
  logic       req;
  logic       hit;
  logic       emptyWrite;
  logic [1:0] unusedAdrLsb;

  assign req          = wbs_cyc_i & wbs_stb_i;
  assign hit          = wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
  assign emptyWrite   = wbs_we_i & (wbs_sel_i == 4'h0);
  assign unusedAdrLsb = wbs_adr_i[1:0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      wmask0    <= 4'h0;
      addr0     <= '0;
      din0      <= '0;
      busy_o    <= 1'b0;
    end else begin
      // SRAM strobes and ack are single-cycle pulses unless a branch reasserts them.
      csb0      <= 1'b1;
      web0      <= 1'b1;
      wbs_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (!hit || emptyWrite) begin
              state     <= ACK;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= '0;
              busy_o    <= 1'b1;
            end else if (!hold_i) begin
              state  <= ACCESS;
              csb0   <= 1'b0;
              web0   <= !wbs_we_i;
              wmask0 <= wbs_we_i ? wbs_sel_i : 4'h0;
              addr0  <= wbs_adr_i[ADDR_W+1:2];
              din0   <= wbs_dat_i;
              busy_o <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // web0 still holds this access's direction while in ACCESS.
          if (!wbs_cyc_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (!web0) begin
            state     <= ACK;
            wbs_ack_o <= 1'b1;
          end else begin
            state <= RWAIT;
          end
        end
        RWAIT: begin
          if (!wbs_cyc_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            state     <= ACK;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= dout0;
          end
        end
        ACK: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_wb_port.sv
// Directed bench for imem_wb_port: transaction-level model of latency, SRAM pins and read data.
module tb_imem_wb_port;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          WORDS = 512;

  logic        wb_clk_i, wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        hold_i;
  logic        csb0, web0;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [31:0] din0, dout0;
  logic        busy_o;

  imem_wb_port dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .hold_i   (hold_i),
    .csb0     (csb0),
    .web0     (web0),
    .wmask0   (wmask0),
    .addr0    (addr0),
    .din0     (din0),
    .dout0    (dout0),
    .busy_o   (busy_o)
  );

  // clock / reset
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // SRAM port-0 model: samples on the rising edge, read data appears after that edge.
  logic [31:0] sram [WORDS];
  always @(posedge wb_clk_i) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) sram[addr0][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        dout0 <= sram[addr0];
      end
    end
  end

  // model state
  logic [31:0] refMem [WORDS];
  int          checks, failures;
  bit          monOn, startPending, active, done;
  int          n, expLat, obsLat;
  bit          expHit, expWe;
  logic [8:0]  expAddr;
  logic [3:0]  expSel;
  logic [31:0] expDin, expDat, holdDat, obsDat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one transaction, from address window and byte-lane rules.
  task automatic setExp(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bit         inWin;
    logic [8:0] w;
    inWin   = (adr >= BASE) && (adr < BASE + 32'(4 * WORDS));
    w       = 9'((adr - BASE) / 4);
    expWe   = we;
    expAddr = w;
    expSel  = we ? sel : 4'h0;
    expDin  = dat;
    if (!inWin || (we && sel == 4'h0)) begin
      expHit = 1'b0; expLat = 1; expDat = 32'h0;
    end else if (we) begin
      expHit = 1'b1; expLat = 2; expDat = holdDat;
      for (int b = 0; b < 4; b++)
        if (sel[b]) refMem[w][8*b +: 8] = dat[8*b +: 8];
    end else begin
      expHit = 1'b1; expLat = 3; expDat = refMem[w];
    end
    done         = 1'b0;
    startPending = 1'b1;
  endtask

  task automatic driveReq(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
  endtask

  task automatic releaseBus();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
  endtask

  task automatic waitDone();
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge wb_clk_i);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: got no ack expected ack within 30 cycles");
      active = 1'b0;
    end
  endtask

  task automatic issue(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    @(posedge wb_clk_i); #1;
    driveReq(we, adr, dat, sel);
    setExp(we, adr, dat, sel);
    waitDone();
    @(posedge wb_clk_i); #1;
    releaseBus();
  endtask

  // compare process: n counts rising edges since the request was first sampled
  always @(negedge wb_clk_i) begin
    if (monOn) begin
      if (startPending) begin
        startPending = 1'b0; active = 1'b1; n = 0;
      end else if (active) begin
        n++;
      end
      if (active && n > 0) begin
        chk("ack",    32'(wbs_ack_o), 32'(n == expLat));
        chk("csb0",   32'(csb0),      32'(!(expHit && n == 1)));
        chk("web0",   32'(web0),      32'(!(expHit && n == 1 && expWe)));
        chk("busy",   32'(busy_o),    32'd1);
        if (expHit && n == 1) begin
          chk("addr0",  32'(addr0),  32'(expAddr));
          chk("wmask0", 32'(wmask0), 32'(expSel));
          chk("din0",   din0,        expDin);
        end
        chk("dat_o", wbs_dat_o, (n == expLat) ? expDat : holdDat);
        if (wbs_ack_o) begin
          obsLat = n; obsDat = wbs_dat_o; holdDat = expDat;
          done = 1'b1; active = 1'b0;
        end else if (n > expLat + 5) begin
          active = 1'b0;
        end
      end else begin
        chk("idle_ack",  32'(wbs_ack_o), 32'd0);
        chk("idle_csb0", 32'(csb0),      32'd1);
        chk("idle_web0", 32'(web0),      32'd1);
        chk("idle_busy", 32'(busy_o),    32'd0);
        chk("idle_dat",  wbs_dat_o,      holdDat);
      end
    end
  end

  initial begin
    checks = 0; failures = 0;
    monOn = 1'b0; startPending = 1'b0; active = 1'b0; done = 1'b0;
    n = 0; obsLat = 0; obsDat = 32'h0; holdDat = 32'h0;
    for (int i = 0; i < WORDS; i++) begin
      sram[i] = 32'h0; refMem[i] = 32'h0;
    end
    dout0 = 32'h0; hold_i = 1'b0;
    releaseBus();
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("rst_csb0",   32'(csb0),      32'd1);
    chk("rst_web0",   32'(web0),      32'd1);
    chk("rst_ack",    32'(wbs_ack_o), 32'd0);
    chk("rst_dat",    wbs_dat_o,      32'h0);
    chk("rst_busy",   32'(busy_o),    32'd0);
    chk("rst_wmask0", 32'(wmask0),    32'd0);
    chk("rst_addr0",  32'(addr0),     32'd0);
    chk("rst_din0",   din0,           32'h0);
    monOn = 1'b1;
    repeat (5) @(negedge wb_clk_i);

    // full write, readback
    issue(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
    chk("wr_lat", 32'(obsLat), 32'd2);
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    chk("rd_lat", 32'(obsLat), 32'd3);
    chk("rd_dat", obsDat, 32'hDEAD_BEEF);

    // byte-lane write
    issue(1'b1, 32'h3000_0010, 32'h00AB_0000, 4'b0100);
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    chk("partial_dat", obsDat, 32'hDEAB_BEEF);

    // misses: one past the window, another region, empty write mask
    issue(1'b0, 32'h3000_0800, 32'h0, 4'hF);
    chk("miss_hi_lat", 32'(obsLat), 32'd1);
    chk("miss_hi_dat", obsDat, 32'h0);
    issue(1'b1, 32'h2000_0000, 32'h1234_5678, 4'hF);
    chk("miss_lo_lat", 32'(obsLat), 32'd1);
    issue(1'b1, 32'h3000_0020, 32'h5555_5555, 4'h0);
    chk("sel0_lat", 32'(obsLat), 32'd1);

    // last word in the window, with ignored byte-offset bits
    issue(1'b1, 32'h3000_07FC, 32'hCAFE_F00D, 4'hF);
    issue(1'b0, 32'h3000_07FF, 32'h0, 4'hF);
    chk("top_dat", obsDat, 32'hCAFE_F00D);

    // hold_i stalls a pending read
    @(posedge wb_clk_i); #1;
    hold_i = 1'b1;
    driveReq(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    repeat (10) @(negedge wb_clk_i);
    @(posedge wb_clk_i); #1;
    hold_i = 1'b0;
    setExp(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    waitDone();
    @(posedge wb_clk_i); #1;
    releaseBus();
    chk("hold_lat", 32'(obsLat), 32'd3);
    chk("hold_dat", obsDat, 32'hDEAB_BEEF);

    // reset while in ACCESS
    monOn = 1'b0;
    @(posedge wb_clk_i); #1;
    driveReq(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    chk("pre_rst_csb0", 32'(csb0), 32'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    releaseBus();
    holdDat = 32'h0;
    monOn = 1'b1;
    repeat (4) @(negedge wb_clk_i);

    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    chk("post_rst_dat", obsDat, 32'hDEAB_BEEF);
    repeat (3) @(negedge wb_clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_wb_port.md
Name: imem_wb_port

Overview:
- Wishbone classic responder that gives the management SoC read/write access to the instruction SRAM's port 0 (rw port).
- The CPU continues to fetch through port 1. The LA loader path writes port 0 only.
- This block adds readback and host-side programming, so host software can load and verify imem contents.
- It sits in the user wrapper between the wbs_* bus and the SRAM's csb0/web0/wmask0/addr0/din0/dout0 pins.

Parameters:
- ADDR_W, 9, SRAM word-address width (512 words).
- DATA_W, 32, SRAM/Wishbone data width.
- BASE_ADDR, 32'h3000_0000, Wishbone byte address of SRAM word 0. Must be aligned to 4*2**ADDR_W.

Ports:
- wb_clk_i  in  1  clock, rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  1=write, 0=read.
- wbs_sel_i  in  4  byte lane select.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  DATA_W  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  DATA_W  read data.
- hold_i  in  1  port 0 owned by LA loader; stall new accesses.
- csb0  out  1  SRAM port-0 chip select, active-low.
- web0  out  1  SRAM port-0 write enable, active-low.
- wmask0  out  4  SRAM byte write mask.
- addr0  out  ADDR_W  SRAM word address.
- din0  out  DATA_W  SRAM write data.
- dout0  in  DATA_W  SRAM read data.
- busy_o  out  1  access in flight (state != IDLE).

Behaviour:
- Reset values, applied at a rising edge with wb_rst_i=1:
  - state=IDLE, wbs_ack_o=0, wbs_dat_o=0, csb0=1, web0=1.
  - wmask0=0, addr0=0, din0=0, busy_o=0.
- All outputs are registered.
- req = wbs_cyc_i & wbs_stb_i.
- hit = wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].
- Word address = wbs_adr_i[ADDR_W+1:2]. wbs_adr_i[1:0] is ignored.
- States: IDLE, ACCESS, RWAIT, ACK.
- IDLE:
  - if req & hit & !hold_i & (wbs_we_i -> sel!=0): go to ACCESS. Drive csb0=0, web0=!wbs_we_i, wmask0=wbs_sel_i (writes) or 0 (reads), addr0, din0=wbs_dat_i.
  - if req & (!hit | (wbs_we_i & sel==0)): go to ACK with wbs_dat_o=0. No SRAM access.
  - if req & hit & hold_i: stay in IDLE. No ack until hold_i falls.
- ACCESS (SRAM samples at the end of this cycle):
  - csb0 and web0 return to 1 at the next edge.
  - Write: go to ACK.
  - Read: go to RWAIT.
- RWAIT: capture dout0 into wbs_dat_o at the end of this cycle, then go to ACK.
- ACK: wbs_ack_o=1 for exactly one cycle, then IDLE.
- The req sampled in the first IDLE cycle after ACK is the master's next request. Wishbone classic: stb is already low then, so there is no double accept.
- Latency from request sampled in IDLE:
  - write hit: ack 2 cycles later.
  - read hit: ack 3 cycles later.
  - miss: ack 1 cycle later.
- wbs_dat_o holds its last value between reads. It is cleared to 0 on a miss ack.
- Abort: if wbs_cyc_i falls in ACCESS, RWAIT or ACK, go to IDLE and suppress/clear ack. A write already sampled by the SRAM stays committed.
- hold_i rising mid-transaction does not abort. The caller guarantees the LA loader waits on busy_o=0.
- Reset mid-transaction: go to IDLE immediately with csb0=1, regardless of state.
- Address wrap: none. Out-of-window addresses always miss.

Decomposition:
- Package imem_pkg holds:
  - IMEM_ADDR_W=9, IMEM_DATA_W=32, IMEM_BASE=32'h3000_0000.
  - The state enum (IDLE, ACCESS, RWAIT, ACK).
- No sub-module. Decode and FSM form a single module.

Test Plan:
- Reset, then idle 5 cycles -> csb0=1, web0=1, ack=0, wbs_dat_o=0, busy_o=0 throughout.
- Write adr=0x3000_0010, dat=0xDEADBEEF, sel=4'hF:
  - one cycle with csb0=0, web0=0, addr0=4, wmask0=4'hF, din0=0xDEADBEEF.
  - ack 2 cycles after request.
- Read adr=0x3000_0010 with SRAM model returning 0xDEADBEEF -> web0=1, addr0=4, ack 3 cycles after request, wbs_dat_o=0xDEADBEEF.
- Partial write sel=4'b0100, dat=0x00AB0000 to word 4, then read -> 0xDEABBEEF.
- Miss adr=0x3000_0800 (word 512) and adr=0x2000_0000 -> ack after 1 cycle, wbs_dat_o=0, csb0 never asserted.
- Edge cases:
  - hold_i=1 with a pending read -> no ack and csb0=1 for 10 cycles. After hold_i falls, normal read with ack 3 cycles later.
  - wb_rst_i asserted in ACCESS -> csb0=1 next cycle, no ack.
